fcb_apbm: RTL and testbench

APB3 requester that turns single-beat command requests into APB transactions toward FCB APB completer blocks. Its APB pins connect directly to a completer's PSEL/PENABLE/PWRITE/PADDR/PWDATA inputs and PREADY/PSLVERR/PRDATA outputs. It is used for on-chip configuration masters such as JTAG-to-APB bridges and test sequencers. It runs one transfer at a time and returns a one-cycle response pulse.

---
 rtl/fcb_apbm_pkg.sv | 13 +
 rtl/fcb_apbm_tmo.sv | 38 +++
 rtl/fcb_apbm.sv | 132 +++++++++++++
 tb/tb_fcb_apbm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fcb_apbm_pkg.sv
// Shared types and default widths for the fcb_apbm APB3 requester.
package fcb_apbm_pkg;

    localparam int unsigned FCB_APBM_ADDR_W = 32;
    localparam int unsigned FCB_APBM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } fcb_apbm_state_e;

endpackage

// File: rtl/fcb_apbm_tmo.sv
// ACCESS-phase wait counter for fcb_apbm; present only in FCB_APBM_TIMEOUT_EN builds.
module fcb_apbm_tmo
    import fcb_apbm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic in_access,
    input  logic pready,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero outside ACCESS, so every ACCESS phase starts from a clean count.
    always_comb begin
        cnt_d = '0;
        if (in_access && !pready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts earlier low cycles; the current low cycle makes it TIMEOUT_CYCLES.
    assign expired = in_access && !pready && (cnt_q == LIMIT);

endmodule

// File: rtl/fcb_apbm.sv
// APB3 requester: one single-beat command at a time, one-cycle response pulse.
// Optional ACCESS timeout abort is enabled with `define FCB_APBM_TIMEOUT_EN.
module fcb_apbm
    import fcb_apbm_pkg::*;
#(
    parameter int unsigned ADDR_W         = FCB_APBM_ADDR_W,
    parameter int unsigned DATA_W         = FCB_APBM_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              FCB_CLK,
    input  logic              FCB_RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              FCB_APBM_PSEL,
    output logic              FCB_APBM_PENABLE,
    output logic              FCB_APBM_PWRITE,
    output logic [ADDR_W-1:0] FCB_APBM_PADDR,
    output logic [DATA_W-1:0] FCB_APBM_PWDATA,
    input  logic              FCB_APBM_PREADY,
    input  logic              FCB_APBM_PSLVERR,
    input  logic [DATA_W-1:0] FCB_APBM_PRDATA
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("fcb_apbm: TIMEOUT_CYCLES must be in 1..65535");
    end

    fcb_apbm_state_e   state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              tmo_expired;

`ifdef FCB_APBM_TIMEOUT_EN
    fcb_apbm_tmo #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk      (FCB_CLK),
        .rst      (FCB_RST),
        .in_access(state_q == ACCESS),
        .pready   (FCB_APBM_PREADY),
        .expired  (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge FCB_CLK or posedge FCB_RST) begin
        if (FCB_RST) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (FCB_APBM_PREADY || tmo_expired) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // APB strobes are registered from the next state so they line up with state_q.
    always_comb begin
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        if (state_q == IDLE && cmd_valid) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_write ? cmd_wdata : '0;
        end
        if (state_q == ACCESS) begin
            if (FCB_APBM_PREADY) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = FCB_APBM_PSLVERR;
                rsp_rdata_d = pwrite_q ? '0 : FCB_APBM_PRDATA;
            end else if (tmo_expired) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
        end
    end

    assign cmd_ready        = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign FCB_APBM_PSEL    = psel_q;
    assign FCB_APBM_PENABLE = penable_q;
    assign FCB_APBM_PWRITE  = pwrite_q;
    assign FCB_APBM_PADDR   = paddr_q;
    assign FCB_APBM_PWDATA  = pwdata_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_err          = rsp_err_q;
    assign rsp_rdata        = rsp_rdata_q;

endmodule

// File: tb/tb_fcb_apbm.sv
// Directed self-checking bench for fcb_apbm (TIMEOUT_CYCLES = 4 in timeout builds).
module tb_fcb_apbm;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;

    fcb_apbm #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .FCB_CLK         (clk),
        .FCB_RST         (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .busy            (busy),
        .FCB_APBM_PSEL   (psel),
        .FCB_APBM_PENABLE(penable),
        .FCB_APBM_PWRITE (pwrite),
        .FCB_APBM_PADDR  (paddr),
        .FCB_APBM_PWDATA (pwdata),
        .FCB_APBM_PREADY (pready),
        .FCB_APBM_PSLVERR(pslverr),
        .FCB_APBM_PRDATA (prdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transfer from acceptance to response; PREADY is held low for 'waits' ACCESS cycles.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input logic err,
                        input logic [31:0] exp_rdata, input logic exp_err);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
        chk("accept_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'hFFFF_FFFF;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_paddr", paddr, a);
        chk("setup_pwrite", pwrite, w);
        chk("setup_pwdata", pwdata, w ? wd : 32'h0);
        chk("setup_busy", busy, 1);
        chk("setup_cmd_ready", cmd_ready, 0);
        pready = 1'b1;
        tick();
        for (int i = 0; i < waits; i++) begin
            chk("wait_psel", psel, 1);
            chk("wait_penable", penable, 1);
            chk("wait_paddr", paddr, a);
            chk("wait_pwrite", pwrite, w);
            chk("wait_rsp_valid", rsp_valid, 0);
            pready = 1'b0; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
            tick();
        end
        chk("access_penable", penable, 1);
        chk("access_paddr", paddr, a);
        pready = 1'b1; pslverr = err; prdata = rd;
        tick();
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_psel", psel, 0);
        chk("rsp_penable", penable, 0);
        chk("rsp_cmd_ready", cmd_ready, 1);
        chk("rsp_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hDEAD_BEEF;
        tick();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        #3 rst = 1'b0;
        tick();
        chk("idle_ignores_pready", rsp_valid, 0);
        pready = 1'b0; pslverr = 1'b0;

        // Zero-wait write.
        xfer(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 0, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
        tick();
        chk("pulse_one_cycle", rsp_valid, 0);
        chk("idle_hold_paddr", paddr, 32'h0000_0010);
        chk("idle_hold_pwdata", pwdata, 32'hA5A5_5A5A);
        chk("idle_hold_pwrite", pwrite, 1);

        // Read with three wait states (also the last legal PREADY cycle in a timeout build).
        xfer(1'b0, 32'h0000_0020, 32'h9999_9999, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0);

        // Slave error on read, then an immediately following read is accepted cleanly.
        xfer(1'b0, 32'h0000_0030, 32'h0, 1, 32'h0000_0055, 1'b1, 32'h0000_0055, 1'b1);
        xfer(1'b0, 32'h0000_0034, 32'h0, 0, 32'h0000_0077, 1'b0, 32'h0000_0077, 1'b0);

        // Write with error: read data forced to zero.
        xfer(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 2, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
        tick();

        // cmd_valid held for four commands against a zero-wait completer.
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0;
        cmd_valid = 1'b1; cmd_write = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            chk("b2b_psel", psel, (c % 3) != 0);
            chk("b2b_rsp_valid", rsp_valid, ((c % 3) == 0) && (c != 0));
            chk("b2b_cmd_ready", cmd_ready, (c % 3) == 0);
            if ((c % 3) == 1) chk("b2b_paddr", paddr, 32'h100 + 32'(c - 1));
            if (c == 10) cmd_valid = 1'b0;
            if ((c % 3) == 0 && c < 12) begin
                cmd_addr = 32'h100 + 32'(c);
                cmd_wdata = 32'(c);
            end
            if (cmd_valid && cmd_ready) n_acc++;
            tick();
        end
        chk("b2b_accepts", n_acc, 4);
        pready = 1'b0;

`ifdef FCB_APBM_TIMEOUT_EN
        // PREADY held low: abort after the fourth ACCESS cycle.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0050;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("tmo_penable", penable, 1);
            chk("tmo_rsp_valid", rsp_valid, 0);
            pready = 1'b0; prdata = 32'hCAFE_CAFE;
            tick();
        end
        chk("tmo_abort_valid", rsp_valid, 1);
        chk("tmo_abort_err", rsp_err, 1);
        chk("tmo_abort_rdata", rsp_rdata, 0);
        chk("tmo_abort_psel", psel, 0);
        chk("tmo_abort_ready", cmd_ready, 1);
        xfer(1'b0, 32'h0000_0054, 32'h0, 3, 32'h0000_ABCD, 1'b0, 32'h0000_ABCD, 1'b0);
`else
        // Without the timeout, ACCESS waits as long as PREADY stays low.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0050;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            pready = 1'b0;
            tick();
        end
        chk("notmo_penable", penable, 1);
        chk("notmo_rsp_valid", rsp_valid, 0);
        pready = 1'b1; prdata = 32'h0000_ABCD;
        tick();
        pready = 1'b0;
        chk("notmo_done_valid", rsp_valid, 1);
        chk("notmo_done_rdata", rsp_rdata, 32'h0000_ABCD);
`endif
        tick();

        // Reset during ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0060; cmd_wdata = 32'h6;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("prerst_penable", penable, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_psel", psel, 0);
        chk("rstmid_penable", penable, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_cmd_ready", cmd_ready, 1);
        #4 rst = 1'b0;
        pready = 1'b1;
        tick();
        chk("postrst_rsp_valid", rsp_valid, 0);
        chk("postrst_cmd_ready", cmd_ready, 1);
        tick();
        chk("postrst_rsp_valid2", rsp_valid, 0);
        pready = 1'b0;
        xfer(1'b0, 32'h0000_0070, 32'h0, 0, 32'h0000_0070, 1'b0, 32'h0000_0070, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
